// File: rtl/dm_bytelane.sv
// Byte-lane data memory for the MEM stage: sub-word stores, extended loads,
// registered read port and alignment/range/mode fault detection.
module dm_bytelane #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          TRACE       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  mode,
  input  logic [31:0] PC,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          fault_q, fault_d;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic          is_word, is_half, is_byte;
  logic          bad;
  logic          wr_en;
  logic          rd_ok;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   merged;
  logic [15:0]   half;
  logic [7:0]    byte_s;
  logic [31:0]   ld_data;

  assign idx  = AW'((addr - BASE_ADDR) >> 2);
  assign lane = addr[1:0];
  assign word = mem_q[idx];

  always_comb begin
    is_word = (mode == 3'd0);
    is_half = (mode == 3'd1) || (mode == 3'd2);
    is_byte = (mode == 3'd3) || (mode == 3'd4);
    bad = !(is_word || is_half || is_byte)
        || (is_word && (lane != 2'd0))
        || (is_half && lane[0])
        || ({1'b0, addr} < {1'b0, BASE_ADDR})
        || ({1'b0, addr} >= LIMIT);
    wr_en = req && we && !bad && !reset;
    rd_ok = req && !we && !bad;

    be = 4'b0000;
    wd = wdata;
    unique case (1'b1)
      is_word: be = 4'b1111;
      is_half: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata[15:0]}};
      end
      is_byte: begin
        be = 4'b0001 << lane;
        wd = {4{wdata[7:0]}};
      end
      default: ;
    endcase

    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : word[8*i +: 8];

    half   = lane[1] ? word[31:16] : word[15:0];
    byte_s = 8'(word >> {lane, 3'b000});
    case (mode)
      3'd0:    ld_data = word;
      3'd1:    ld_data = {16'h0, half};
      3'd2:    ld_data = {{16{half[15]}}, half};
      3'd3:    ld_data = {24'h0, byte_s};
      3'd4:    ld_data = {{24{byte_s[7]}}, byte_s};
      default: ld_data = 32'h0;
    endcase

    rdata_d  = rd_ok ? ld_data : 32'h0;
    rvalid_d = rd_ok;
    fault_d  = req && bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++)
        mem_q[i] <= 32'h0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      fault_q  <= fault_d;
      if (wr_en)
        mem_q[idx] <= merged;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign fault  = fault_q;

  // Store trace shows the whole word as it will read back after the edge.
  if (TRACE) begin : g_trace
`ifndef SYNTHESIS
    always @(posedge clk)
      if (wr_en)
        $display("@%h: *%h <= %h", PC, {addr[31:2], 2'b00}, merged);
`endif
  end

endmodule

// File: tb/tb_dm_bytelane.sv
// Directed bench for dm_bytelane: reset, sub-word stores/loads,
// faults, back-to-back traffic and reset during a request.
module tb_dm_bytelane;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  mode;
  logic [31:0] PC;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_bytelane dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .mode   (mode),
    .PC     (PC),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .fault  (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request cycle; outputs sampled 1 ns after the ending edge.
  task automatic step(input logic rs, input logic rq, input logic w,
                      input logic [2:0] md, input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    reset = rs;
    req   = rq;
    we    = w;
    mode  = md;
    addr  = a;
    wdata = d;
    PC    = PC + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [31:0] rd,
                      input logic rv, input logic f);
    chk({tag, ".rdata"}, rdata, rd);
    chk({tag, ".rvalid"}, {31'h0, rvalid}, {31'h0, rv});
    chk({tag, ".fault"}, {31'h0, fault}, {31'h0, f});
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; mode = 3'd0;
    PC = 32'h0000_1000; addr = 32'h0; wdata = 32'h0;

    step(1, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 32'h0);
    outs("reset", 32'h0, 0, 0);

    step(0, 1, 1, 0, 32'h8, 32'hDEAD_BEEF);
    outs("sw8", 32'h0, 0, 0);
    step(0, 1, 0, 0, 32'h8, 32'h0);
    outs("lw8", 32'hDEAD_BEEF, 1, 0);

    step(0, 1, 1, 3, 32'h9, 32'h0000_0012);
    step(0, 1, 0, 0, 32'h8, 32'h0);
    outs("sb9", 32'hDEAD_12EF, 1, 0);
    step(0, 1, 1, 2, 32'hA, 32'h0000_8001);
    step(0, 1, 0, 0, 32'h8, 32'h0);
    outs("shA", 32'h8001_12EF, 1, 0);

    step(0, 1, 0, 4, 32'hB, 32'h0);
    outs("lbB", 32'hFFFF_FF80, 1, 0);
    step(0, 1, 0, 3, 32'hB, 32'h0);
    outs("lbuB", 32'h0000_0080, 1, 0);
    step(0, 1, 0, 2, 32'hA, 32'h0);
    outs("lhA", 32'hFFFF_8001, 1, 0);
    step(0, 1, 0, 1, 32'hA, 32'h0);
    outs("lhuA", 32'h0000_8001, 1, 0);
    step(0, 1, 0, 3, 32'h8, 32'h0);
    outs("lbu8", 32'h0000_00EF, 1, 0);
    step(0, 1, 0, 2, 32'h8, 32'h0);
    outs("lh8", 32'h0000_12EF, 1, 0);

    step(0, 1, 1, 0, 32'h4, 32'h1122_3344);
    step(0, 1, 0, 0, 32'h6, 32'h0);
    outs("lw6", 32'h0, 0, 1);
    step(0, 1, 1, 1, 32'h5, 32'h0000_FFFF);
    outs("sh5", 32'h0, 0, 1);
    step(0, 1, 0, 0, 32'h4, 32'h0);
    outs("lw4", 32'h1122_3344, 1, 0);

    step(0, 1, 1, 0, 32'h1000, 32'h0000_0055);
    outs("sw1000", 32'h0, 0, 1);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    outs("lw0a", 32'h0, 1, 0);
    step(0, 1, 0, 0, 32'h1000, 32'h0);
    outs("lw1000", 32'h0, 0, 1);
    step(0, 1, 0, 6, 32'h8, 32'h0);
    outs("mode6", 32'h0, 0, 1);
    step(0, 1, 1, 5, 32'h0, 32'hFFFF_FFFF);
    outs("mode5", 32'h0, 0, 1);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    outs("lw0b", 32'h0, 1, 0);
    step(0, 1, 1, 0, 32'hFFC, 32'hCAFE_F00D);
    step(0, 1, 0, 0, 32'hFFC, 32'h0);
    outs("lwFFC", 32'hCAFE_F00D, 1, 0);

    step(0, 1, 1, 0, 32'h10, 32'hA5A5_0001);
    step(0, 1, 0, 0, 32'h10, 32'h0);
    outs("b2b1", 32'hA5A5_0001, 1, 0);
    step(0, 1, 1, 0, 32'h10, 32'h5A5A_0002);
    outs("b2b_sw", 32'h0, 0, 0);
    step(0, 1, 0, 0, 32'h10, 32'h0);
    outs("b2b2", 32'h5A5A_0002, 1, 0);

    step(0, 0, 0, 0, 32'h10, 32'h0);
    outs("idle", 32'h0, 0, 0);
    step(0, 0, 1, 0, 32'h10, 32'h1234_5678);
    step(0, 1, 0, 0, 32'h10, 32'h0);
    outs("idle_sw", 32'h5A5A_0002, 1, 0);

    step(0, 1, 0, 0, 32'h8, 32'h0);
    step(1, 1, 1, 0, 32'h0, 32'h0000_0001);
    outs("rst_mid", 32'h0, 0, 0);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    outs("lw0c", 32'h0, 1, 0);
    step(0, 1, 0, 0, 32'h8, 32'h0);
    outs("lw8clr", 32'h0, 1, 0);
    step(0, 1, 0, 0, 32'h10, 32'h0);
    outs("lw10clr", 32'h0, 1, 0);

    step(0, 0, 0, 0, 32'h0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm_bytelane.md
# dm_bytelane

Parametrised data memory for the five-stage MIPS core, successor to the word-only DM. It adds byte/halfword store lanes, signed/unsigned sub-word load extension, a registered one-cycle read port, a programmable base address and depth, and alignment/range fault detection. It sits in the MEM stage: the core issues one request per cycle, and load data with its fault flag returns one cycle later for the W-stage register file write.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; DEPTH_WORDS×4-aligned.
- `TRACE`, 1: when 1, every committed store prints a trace line.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input 1: access request valid this cycle.
- `we` input 1: 1 = store, 0 = load; ignored when `req`=0.
- `mode` input 3: 0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed; 5–7 illegal. Modes 1/2 and 3/4 behave identically for stores.
- `PC` input 32: PC of the issuing instruction; used only for trace.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `rdata` output 32: extended load data, valid when `rvalid`=1.
- `rvalid` output 1: load response valid.
- `fault` output 1: the request from the previous cycle was rejected.

## Operation
- Word index = (addr − BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0].
- Fault conditions are evaluated combinationally on the request cycle:
  - illegal mode;
  - word mode with addr[1:0] ≠ 0;
  - half mode with addr[0] ≠ 0;
  - addr < BASE_ADDR or addr ≥ BASE_ADDR + 4·DEPTH_WORDS.
- A faulting request never modifies memory and returns `rdata`=0.
- Store byte enables:
  - word: 4'b1111.
  - half: lane 0 → 4'b0011, lane 2 → 4'b1100; data replicated to both halves.
  - byte: 4'b0001 << lane; data replicated to all four bytes.
  - Only enabled bytes change.
- Load: read the full word, select a byte or half by lane, then zero- or sign-extend per mode.
- Trace (TRACE=1, committed store only): `"@%h: *%h <= %h"` with PC, the word-aligned byte address, and the full merged 32-bit word after the write.
- Memory content is 0 at time zero and is cleared to all-zero by `reset`.

## Timing
- Stores commit at the rising edge that ends the request cycle.
- Loads: the request is sampled at edge N; `rdata`/`rvalid` are driven in cycle N+1 and held for exactly one cycle.
- `rvalid` goes to 1 only for a non-faulting load. It stays 0 after stores, faults and idle cycles.
- `fault` goes to 1 in cycle N+1 for any faulting request, load or store, and is held for one cycle.
- Back-to-back requests are accepted every cycle with no stall.
- A load issued in the cycle right after a store to the same word sees the new data.
- Reset values: `rdata`=0, `rvalid`=0, `fault`=0, all memory words 0.
- `reset` asserted in a request cycle:
  - the request is discarded, with no write and no trace;
  - the outputs in the next cycle are all 0;
  - reset has priority over every other event.
- `req`=0: no memory change, and the next-cycle outputs are 0.

## Test plan
- Reset, then sw 32'hDEADBEEF @BASE+8 followed by lw @BASE+8: `rvalid`=1 and `rdata`=32'hDEADBEEF one cycle after the lw; trace prints `*00000008 <= deadbeef` (BASE=0).
- After storing 0xDEADBEEF at 0x8:
  - sb 8'h12 @0x9 → word becomes 32'hDEAD12EF;
  - sh 16'h8001 @0xA → word becomes 32'h800112EF;
  - lb @0xB → 32'hFFFFFF80; lbu @0xB → 32'h00000080; lh @0xA → 32'hFFFF8001.
- Misalignment: lw @0x6 and sh @0x5 each give `fault`=1 and `rvalid`=0 in the next cycle; a following lw @0x4 still returns the old data.
- Range and mode: with DEPTH_WORDS=1024 and BASE=0, sw @0x1000 faults and changes no memory; `mode`=6 faults.
- Back-to-back: sw A, lw A, sw A, lw A on consecutive cycles; each lw returns the preceding store's data with no bubbles.
- Reset mid-stream: assert `reset` in the same cycle as sw 32'h1 @0x0 → no write, no trace, all outputs 0 next cycle; a later lw @0x0 returns 0.
